// File: rtl/memory_stage_if.sv
// Data-cache request/acknowledge port of the MEM stage.
// master : the MEM stage; drives dc_req/dc_we/dc_addr/dc_size/dc_wdata and takes dc_ack/dc_rdata.
// slave  : the data cache; the reverse directions.
// dc_size encodes 0=byte 1=half 2=word 3=double. Data is right-justified in both directions.
interface memory_stage_if #(
  parameter int unsigned ADDR_WIDTH = 64,
  parameter int unsigned DATA_WIDTH = 64
);
  logic                  dc_req;
  logic                  dc_we;
  logic [ADDR_WIDTH-1:0] dc_addr;
  logic [1:0]            dc_size;
  logic [DATA_WIDTH-1:0] dc_wdata;
  logic                  dc_ack;
  logic [DATA_WIDTH-1:0] dc_rdata;

  modport master (
    output dc_req, dc_we, dc_addr, dc_size, dc_wdata,
    input  dc_ack, dc_rdata
  );

  modport slave (
    input  dc_req, dc_we, dc_addr, dc_size, dc_wdata,
    output dc_ack, dc_rdata
  );
endinterface

// File: rtl/memory_stage.sv
// MEM stage of the SPARC pipeline. Takes Execute's result bundle, performs loads/stores over
// the data-cache port and emits one registered writeback bundle per instruction.
// Ports:
//   clk, reset          clock (posedge) and asynchronous active-low reset
//   MEM_*_in            result bundle from Execute (held stable while mem_ready=0)
//   mem_ready           1 = the bundle is accepted on the current edge
//   dc                  data-cache port (memory_stage_if.master)
//   WB_*                writeback bundle, WB_valid pulses for one cycle per instruction
//   mem_trap            misaligned access, pulses together with WB_valid
module memory_stage #(
  parameter int unsigned ADDR_WIDTH = 64,
  parameter int unsigned DATA_WIDTH = 64
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [63:0]          MEM_alures_in,
  input  logic [63:0]          MEM_valD_in,
  input  logic [1:0]           MEM_op_in,
  input  logic [2:0]           MEM_op2_in,
  input  logic [5:0]           MEM_op3_in,
  input  logic [4:0]           MEM_rd_in,
  input  logic                 MEM_regWrite_in,
  input  logic                 MEM_regWriteDouble_in,
  input  logic                 MEM_icc_write_in,
  input  logic                 MEM_Y_write_in,
  input  logic [3:0]           MEM_icc_in,
  input  logic [31:0]          MEM_Y_in,
  output logic                 mem_ready,
  memory_stage_if.master       dc,
  output logic                 WB_valid,
  output logic [4:0]           WB_rd,
  output logic [63:0]          WB_data,
  output logic                 WB_regWrite,
  output logic                 WB_regWriteDouble,
  output logic [3:0]           WB_icc,
  output logic                 WB_icc_write,
  output logic [31:0]          WB_Y,
  output logic                 WB_Y_write,
  output logic                 mem_trap
);
  localparam logic [5:0] Op3Ld   = 6'b000000;
  localparam logic [5:0] Op3Ldub = 6'b000001;
  localparam logic [5:0] Op3Lduh = 6'b000010;
  localparam logic [5:0] Op3Ldd  = 6'b000011;
  localparam logic [5:0] Op3St   = 6'b000100;
  localparam logic [5:0] Op3Stb  = 6'b000101;
  localparam logic [5:0] Op3Sth  = 6'b000110;
  localparam logic [5:0] Op3Std  = 6'b000111;
  localparam logic [5:0] Op3Ldsb = 6'b001001;
  localparam logic [5:0] Op3Ldsh = 6'b001010;

  typedef enum logic [0:0] {StIdle, StAccess} state_e;

  state_e                state_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [1:0]            size_q;
  logic                  we_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [5:0]            op3_q;
  logic                  pend_rw_q;
  logic                  pend_rwd_q;

  // Instruction decode of the incoming bundle.
  logic        is_load, is_store, is_mem, is_bubble, misaligned;
  logic [1:0]  size;
  logic [63:0] wdata_fmt;

  always_comb begin
    is_load  = 1'b0;
    is_store = 1'b0;
    size     = 2'd0;
    case (MEM_op3_in)
      Op3Ld:   begin is_load  = 1'b1; size = 2'd2; end
      Op3Ldub: begin is_load  = 1'b1; size = 2'd0; end
      Op3Lduh: begin is_load  = 1'b1; size = 2'd1; end
      Op3Ldd:  begin is_load  = 1'b1; size = 2'd3; end
      Op3Ldsb: begin is_load  = 1'b1; size = 2'd0; end
      Op3Ldsh: begin is_load  = 1'b1; size = 2'd1; end
      Op3St:   begin is_store = 1'b1; size = 2'd2; end
      Op3Stb:  begin is_store = 1'b1; size = 2'd0; end
      Op3Sth:  begin is_store = 1'b1; size = 2'd1; end
      Op3Std:  begin is_store = 1'b1; size = 2'd3; end
      default: ;
    endcase
    is_mem    = (MEM_op_in == 2'b11) && (is_load || is_store);
    is_bubble = (MEM_op_in == 2'b00) && (MEM_op2_in == 3'b100) && (MEM_rd_in == 5'd0);
    case (size)
      2'd1:    misaligned = MEM_alures_in[0];
      2'd2:    misaligned = |MEM_alures_in[1:0];
      2'd3:    misaligned = |MEM_alures_in[2:0];
      default: misaligned = 1'b0;
    endcase
    case (size)
      2'd0:    wdata_fmt = {56'd0, MEM_valD_in[7:0]};
      2'd1:    wdata_fmt = {48'd0, MEM_valD_in[15:0]};
      2'd2:    wdata_fmt = {32'd0, MEM_valD_in[31:0]};
      default: wdata_fmt = MEM_valD_in;
    endcase
  end

  // Load result formatting against the latched opcode.
  logic [63:0] rdata;
  logic [63:0] load_fmt;

  assign rdata = 64'(dc.dc_rdata);

  always_comb begin
    case (op3_q)
      Op3Ldub: load_fmt = {56'd0, rdata[7:0]};
      Op3Lduh: load_fmt = {48'd0, rdata[15:0]};
      Op3Ldsb: load_fmt = {{56{rdata[7]}}, rdata[7:0]};
      Op3Ldsh: load_fmt = {{48{rdata[15]}}, rdata[15:0]};
      Op3Ldd:  load_fmt = rdata;
      default: load_fmt = {32'd0, rdata[31:0]};
    endcase
  end

  assign mem_ready   = (state_q == StIdle);
  assign dc.dc_req   = (state_q == StAccess);
  assign dc.dc_we    = we_q;
  assign dc.dc_addr  = addr_q;
  assign dc.dc_size  = size_q;
  assign dc.dc_wdata = wdata_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q           <= StIdle;
      addr_q            <= '0;
      size_q            <= 2'd0;
      we_q              <= 1'b0;
      wdata_q           <= '0;
      op3_q             <= 6'd0;
      pend_rw_q         <= 1'b0;
      pend_rwd_q        <= 1'b0;
      WB_valid          <= 1'b0;
      WB_rd             <= 5'd0;
      WB_data           <= 64'd0;
      WB_regWrite       <= 1'b0;
      WB_regWriteDouble <= 1'b0;
      WB_icc            <= 4'd0;
      WB_icc_write      <= 1'b0;
      WB_Y              <= 32'd0;
      WB_Y_write        <= 1'b0;
      mem_trap          <= 1'b0;
    end else begin
      WB_valid <= 1'b0;
      mem_trap <= 1'b0;
      unique case (state_q)
        StIdle: begin
          // Sideband fields are taken now; data and regWrite follow on ack for mem ops.
          WB_icc <= MEM_icc_in;
          WB_Y   <= MEM_Y_in;
          if (is_mem && misaligned) begin
            WB_valid          <= 1'b1;
            mem_trap          <= 1'b1;
            WB_rd             <= MEM_rd_in;
            WB_data           <= MEM_alures_in;
            WB_regWrite       <= 1'b0;
            WB_regWriteDouble <= 1'b0;
            WB_icc_write      <= 1'b0;
            WB_Y_write        <= 1'b0;
          end else if (is_mem) begin
            state_q      <= StAccess;
            addr_q       <= MEM_alures_in[ADDR_WIDTH-1:0];
            size_q       <= size;
            we_q         <= is_store;
            wdata_q      <= DATA_WIDTH'(wdata_fmt);
            op3_q        <= MEM_op3_in;
            pend_rw_q    <= is_load && MEM_regWrite_in;
            pend_rwd_q   <= (MEM_op3_in == Op3Ldd);
            // LDD targets an even/odd pair; an odd rd names the pair's even register.
            WB_rd        <= (MEM_op3_in == Op3Ldd) ? {MEM_rd_in[4:1], 1'b0} : MEM_rd_in;
            WB_icc_write <= MEM_icc_write_in;
            WB_Y_write   <= MEM_Y_write_in;
          end else begin
            WB_valid          <= !is_bubble;
            WB_rd             <= MEM_rd_in;
            WB_data           <= MEM_alures_in;
            WB_regWrite       <= MEM_regWrite_in && !is_bubble;
            WB_regWriteDouble <= MEM_regWriteDouble_in && !is_bubble;
            WB_icc_write      <= MEM_icc_write_in && !is_bubble;
            WB_Y_write        <= MEM_Y_write_in && !is_bubble;
          end
        end
        StAccess: begin
          if (dc.dc_ack) begin
            state_q           <= StIdle;
            we_q              <= 1'b0;
            WB_valid          <= 1'b1;
            WB_data           <= we_q ? 64'(addr_q) : load_fmt;
            WB_regWrite       <= pend_rw_q;
            WB_regWriteDouble <= pend_rwd_q;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end
endmodule

// File: tb/tb_memory_stage.sv
module tb_memory_stage;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [63:0] alures, vald;
  logic [1:0]  op;
  logic [2:0]  op2;
  logic [5:0]  op3;
  logic [4:0]  rd;
  logic        rw, rwd, iccw, yw;
  logic [3:0]  icc;
  logic [31:0] y;
  logic        mem_ready;
  logic        WB_valid, WB_regWrite, WB_regWriteDouble, WB_icc_write, WB_Y_write, mem_trap;
  logic [4:0]  WB_rd;
  logic [63:0] WB_data;
  logic [3:0]  WB_icc;
  logic [31:0] WB_Y;

  memory_stage_if #(.ADDR_WIDTH(64), .DATA_WIDTH(64)) dc_bus ();

  memory_stage #(.ADDR_WIDTH(64), .DATA_WIDTH(64)) dut (
    .clk(clk), .reset(reset),
    .MEM_alures_in(alures), .MEM_valD_in(vald), .MEM_op_in(op), .MEM_op2_in(op2),
    .MEM_op3_in(op3), .MEM_rd_in(rd), .MEM_regWrite_in(rw), .MEM_regWriteDouble_in(rwd),
    .MEM_icc_write_in(iccw), .MEM_Y_write_in(yw), .MEM_icc_in(icc), .MEM_Y_in(y),
    .mem_ready(mem_ready), .dc(dc_bus),
    .WB_valid(WB_valid), .WB_rd(WB_rd), .WB_data(WB_data), .WB_regWrite(WB_regWrite),
    .WB_regWriteDouble(WB_regWriteDouble), .WB_icc(WB_icc), .WB_icc_write(WB_icc_write),
    .WB_Y(WB_Y), .WB_Y_write(WB_Y_write), .mem_trap(mem_trap)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] op; logic [2:0] op2; logic [5:0] op3; logic [4:0] rd;
    logic [63:0] alures; logic [63:0] vald;
    logic rw; logic rwd; logic iccw; logic yw; logic [3:0] icc; logic [31:0] y;
    int ack_delay; logic [63:0] rdata;
  } instr_t;

  typedef struct {
    int cyc; logic [4:0] rd; logic [63:0] data;
    logic rw; logic rwd; logic iccw; logic yw; logic trap; logic [3:0] icc; logic [31:0] y;
    bit chk_rd; bit chk_data;
  } wb_t;

  int  tests = 0;
  int  fails = 0;
  int  cyc = 0;
  bit  run = 0;
  wb_t exp_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Memory-access width in bytes; 0 for anything that is not a load/store.
  function automatic int access_bytes(input instr_t t);
    if (t.op != 2'b11) return 0;
    case (t.op3)
      6'h01, 6'h09, 6'h05: return 1;
      6'h02, 6'h0A, 6'h06: return 2;
      6'h00, 6'h04:        return 4;
      6'h03, 6'h07:        return 8;
      default:             return 0;
    endcase
  endfunction

  function automatic bit is_store(input instr_t t);
    return access_bytes(t) != 0 && t.op3 >= 6'h04 && t.op3 <= 6'h07;
  endfunction

  function automatic bit is_bubble(input instr_t t);
    return t.op == 2'b00 && t.op2 == 3'b100 && t.rd == 5'd0;
  endfunction

  function automatic logic [63:0] low_mask(input int bytes);
    if (bytes >= 8) return '1;
    return (64'd1 << (8 * bytes)) - 64'd1;
  endfunction

  // Expected writeback bundle from the instruction's architectural meaning.
  function automatic wb_t model(input instr_t t);
    wb_t m;
    int  n;
    logic [63:0] v;
    n = access_bytes(t);
    m = '{cyc: 0, rd: t.rd, data: t.alures, rw: t.rw, rwd: t.rwd, iccw: t.iccw, yw: t.yw,
          trap: 0, icc: t.icc, y: t.y, chk_rd: 1, chk_data: 1};
    if (n == 0) return m;
    if (t.alures % n != 0) begin
      m.trap = 1; m.rw = 0; m.rwd = 0; m.iccw = 0; m.yw = 0;
      m.chk_rd = 0; m.chk_data = 0;
      return m;
    end
    if (is_store(t)) begin
      m.rw = 0; m.rwd = 0; m.chk_rd = 0; m.chk_data = 0;
      return m;
    end
    v = t.rdata & low_mask(n);
    if (t.op3 == 6'h09 && v >= 64'd128)   v = v - 64'd256;
    if (t.op3 == 6'h0A && v >= 64'd32768) v = v - 64'd65536;
    m.data = v;
    m.rwd  = (n == 8);
    if (n == 8) m.rd = t.rd - (t.rd % 2);
    return m;
  endfunction

  always @(negedge clk) begin
    if (run) begin
      if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
        check("wb_valid", 64'(WB_valid), 64'd1);
        check("mem_trap", 64'(mem_trap), 64'(exp_q[0].trap));
        check("wb_regwrite", 64'(WB_regWrite), 64'(exp_q[0].rw));
        check("wb_regwritedouble", 64'(WB_regWriteDouble), 64'(exp_q[0].rwd));
        check("wb_icc_write", 64'(WB_icc_write), 64'(exp_q[0].iccw));
        check("wb_y_write", 64'(WB_Y_write), 64'(exp_q[0].yw));
        check("wb_icc", 64'(WB_icc), 64'(exp_q[0].icc));
        check("wb_y", 64'(WB_Y), 64'(exp_q[0].y));
        if (exp_q[0].chk_rd) check("wb_rd", 64'(WB_rd), 64'(exp_q[0].rd));
        if (exp_q[0].chk_data) check("wb_data", WB_data, exp_q[0].data);
        void'(exp_q.pop_front());
      end else begin
        check("wb_valid_idle", 64'(WB_valid), 64'd0);
        check("mem_trap_idle", 64'(mem_trap), 64'd0);
      end
    end
  end

  task automatic drive(input instr_t t);
    op = t.op; op2 = t.op2; op3 = t.op3; rd = t.rd; alures = t.alures; vald = t.vald;
    rw = t.rw; rwd = t.rwd; iccw = t.iccw; yw = t.yw; icc = t.icc; y = t.y;
  endtask

  function automatic instr_t mk(input logic [1:0] o, input logic [5:0] o3, input logic [4:0] r,
                                input logic [63:0] a, input logic [63:0] v, input logic w,
                                input int ack, input logic [63:0] rdat);
    instr_t t;
    t = '{op: o, op2: 3'b000, op3: o3, rd: r, alures: a, vald: v, rw: w, rwd: 0,
          iccw: 0, yw: 0, icc: 4'h0, y: 32'h0, ack_delay: ack, rdata: rdat};
    return t;
  endfunction

  function automatic instr_t bubble();
    instr_t t;
    t = mk(2'b00, 6'd0, 5'd0, 64'd0, 64'd0, 0, 0, 64'd0);
    t.op2 = 3'b100;
    return t;
  endfunction

  // Called #1 after a posedge with the DUT idle; returns #1 after the WB edge.
  task automatic do_instr(input instr_t t);
    wb_t m;
    int  n;
    n = access_bytes(t);
    m = model(t);
    drive(t);
    @(posedge clk); #1;
    if (n == 0 || t.alures % n != 0) begin
      if (!is_bubble(t)) begin m.cyc = cyc; exp_q.push_back(m); end
      if (n != 0) check("no_req_misaligned", 64'(dc_bus.dc_req), 64'd0);
      check("ready_after_accept", 64'(mem_ready), 64'd1);
    end else begin
      for (int i = 1; i <= t.ack_delay; i++) begin
        check("dc_req", 64'(dc_bus.dc_req), 64'd1);
        check("mem_ready_busy", 64'(mem_ready), 64'd0);
        check("dc_addr", dc_bus.dc_addr, t.alures);
        check("dc_size", 64'(dc_bus.dc_size), 64'($clog2(n)));
        check("dc_we", 64'(dc_bus.dc_we), 64'(is_store(t)));
        if (is_store(t)) check("dc_wdata", dc_bus.dc_wdata, t.vald & low_mask(n));
        if (i == t.ack_delay) begin dc_bus.dc_ack = 1'b1; dc_bus.dc_rdata = t.rdata; end
        @(posedge clk); #1;
      end
      dc_bus.dc_ack = 1'b0;
      m.cyc = cyc;
      exp_q.push_back(m);
      check("dc_req_drop", 64'(dc_bus.dc_req), 64'd0);
      check("ready_after_ack", 64'(mem_ready), 64'd1);
    end
    drive(bubble());
  endtask

  instr_t t;

  initial begin
    dc_bus.dc_ack = 1'b0;
    dc_bus.dc_rdata = 64'd0;
    drive(bubble());
    #3;
    check("rst_mem_ready", 64'(mem_ready), 64'd1);
    check("rst_dc_req", 64'(dc_bus.dc_req), 64'd0);
    check("rst_wb_valid", 64'(WB_valid), 64'd0);
    check("rst_wb_data", WB_data, 64'd0);
    check("rst_mem_trap", 64'(mem_trap), 64'd0);
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b1;
    run = 1;
    @(posedge clk); #1;

    // Non-mem ALU result.
    do_instr(mk(2'b10, 6'd0, 5'd5, 64'h2A, 64'd0, 1, 0, 64'd0));
    check("lit_nonmem_rd", 64'(WB_rd), 64'd5);
    check("lit_nonmem_data", WB_data, 64'h2A);

    // LDSB, ack in the third ACCESS cycle.
    do_instr(mk(2'b11, 6'h09, 5'd3, 64'h1003, 64'd0, 1, 3, 64'h80));
    check("lit_ldsb_data", WB_data, 64'hFFFF_FFFF_FFFF_FF80);

    // STD with immediate ack; icc/Y enables pass through.
    t = mk(2'b11, 6'h07, 5'd4, 64'h2000, 64'h1111_2222_3333_4444, 1, 1, 64'd0);
    t.iccw = 1; t.icc = 4'hA; t.yw = 1; t.y = 32'h1234_5678;
    do_instr(t);
    check("lit_std_regwrite", 64'(WB_regWrite), 64'd0);

    // Misaligned LD.
    do_instr(mk(2'b11, 6'h00, 5'd8, 64'h2002, 64'd0, 1, 1, 64'd0));
    check("lit_ld_trap", 64'(mem_trap), 64'd1);

    // LDD with odd rd.
    do_instr(mk(2'b11, 6'h03, 5'd7, 64'h3000, 64'd0, 1, 2, 64'hAAAA_BBBB_CCCC_DDDD));
    check("lit_ldd_rd", 64'(WB_rd), 64'd6);
    check("lit_ldd_data", WB_data, 64'hAAAA_BBBB_CCCC_DDDD);

    // Remaining load/store variants and a few corner cases.
    do_instr(mk(2'b11, 6'h01, 5'd9, 64'h1001, 64'd0, 1, 1, 64'hFFFF_FFFF_FFFF_F0F5));
    check("lit_ldub_data", WB_data, 64'hF5);
    do_instr(mk(2'b11, 6'h02, 5'd10, 64'h1002, 64'd0, 1, 2, 64'h7777_6666_5555_8001));
    do_instr(mk(2'b11, 6'h0A, 5'd11, 64'h1004, 64'd0, 1, 1, 64'h7777_6666_5555_8001));
    check("lit_ldsh_data", WB_data, 64'hFFFF_FFFF_FFFF_8001);
    do_instr(mk(2'b11, 6'h00, 5'd12, 64'h1008, 64'd0, 1, 4, 64'hDEAD_BEEF_CAFE_F00D));
    do_instr(mk(2'b11, 6'h05, 5'd13, 64'h1001, 64'h0102_0304_0506_07AB, 0, 1, 64'd0));
    do_instr(mk(2'b11, 6'h06, 5'd14, 64'h1006, 64'h0102_0304_0506_C0DE, 0, 2, 64'd0));
    do_instr(mk(2'b11, 6'h04, 5'd15, 64'h1004, 64'hFFFF_FFFF_8765_4321, 0, 1, 64'd0));
    do_instr(mk(2'b11, 6'h06, 5'd14, 64'h1001, 64'd0, 0, 1, 64'd0));
    do_instr(mk(2'b11, 6'h07, 5'd2, 64'h2004, 64'd0, 0, 1, 64'd0));
    // op=11 with a non-load/store op3 is an ordinary result.
    t = mk(2'b11, 6'h3C, 5'd17, 64'h5555, 64'd0, 1, 0, 64'd0);
    t.iccw = 1; t.icc = 4'h5; t.yw = 1; t.y = 32'hCAFE_0001;
    do_instr(t);
    // Explicit bubble, with a stray ack while idle.
    dc_bus.dc_ack = 1'b1; dc_bus.dc_rdata = 64'h99;
    do_instr(bubble());
    dc_bus.dc_ack = 1'b0;

    // Reset in the middle of an access.
    drive(mk(2'b11, 6'h00, 5'd20, 64'h4000, 64'd0, 1, 1, 64'd0));
    @(posedge clk); #1;
    check("pre_rst_dc_req", 64'(dc_bus.dc_req), 64'd1);
    #2 reset = 1'b0;
    #1;
    check("async_rst_dc_req", 64'(dc_bus.dc_req), 64'd0);
    check("async_rst_ready", 64'(mem_ready), 64'd1);
    drive(bubble());
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    dc_bus.dc_ack = 1'b1; dc_bus.dc_rdata = 64'h1234;
    @(posedge clk); #1;
    dc_bus.dc_ack = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("no_pending_expect", 64'(exp_q.size()), 64'd0);
    run = 0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no finish, expected finish");
    $fatal(1);
  end
endmodule
